muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit with its own sequencer. Owns the HI/LO pair.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
//  Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle.
//  Asserts busy so hazard logic can stall MFHI/MFLO and later mul/div ops.
// PARAMETERS
//  WORD_W  32  operand/HI/LO width; RUN phase takes WORD_W cycles
// PORTS
//  CLK      in   1       clock, rising edge
//  RST      in   1       asynchronous active-high reset
//  start    in   1       request; sampled only in IDLE
//  func     in   6       R-type funct: MULT 18h, MULTU 19h, DIV 1Ah, DIVU 1Bh, MTHI 11h, MTLO 13h
//  rs_data  in   WORD_W  multiplicand/dividend; MTHI/MTLO source
//  rt_data  in   WORD_W  multiplier/divisor
//  flush    in   1       abort current operation (branch squash)
//  busy     out  1       operation in flight; HI/LO not yet valid
//  done     out  1       1-cycle pulse; HI/LO hold the new result this cycle
//  hi       out  WORD_W  HI register (product high / remainder)
//  lo       out  WORD_W  LO register (product low / quotient)
//  divz     out  1       divide-by-zero pulse (present only with MULDIV_DIVZERO_EN)
// BEHAVIOUR
//  Reset, async: state=IDLE, hi=lo=0, busy=done=divz=0, counter=0.
//    Reset mid-operation aborts the operation. No result is written.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  IDLE, start=1 with a mul/div func, at edge E0:
//    Latch |rs| and |rt| (raw values for unsigned ops), the op, and the sign bits.
//    Go to RUN with counter=0. busy=1 from E0.
//  IDLE, start=1 with MTHI/MTLO: write rs_data to hi/lo at E0.
//    busy and done stay 0.
//  IDLE, start=1 with any other func: ignored.
//  RUN: one iteration per edge. counter+1 each edge.
//    Leave to FIX when counter reaches WORD_W-1.
//    Multiply: 2*WORD_W-bit accumulator. Conditional add, then shift right.
//    Divide: restoring algorithm. Partial remainder is WORD_W+1 bits wide.
//  FIX, one edge:
//    Signed mult: negate the product if the operand signs differ.
//    Signed div: quotient negative if signs differ; remainder takes the dividend sign.
//    Write hi/lo at this edge (E0+WORD_W+1). Go to IDLE.
//  Next cycle: done=1 and busy=0.
//    Latency: done is high WORD_W+1 cycles after E0 (33 for WORD_W=32).
//    busy is high for WORD_W+1 cycles.
//  start while busy: ignored. The issuing stage must stall on busy.
//  flush=1 in RUN or FIX: go to IDLE at the next edge.
//    hi/lo keep their previous values. No done.
//  flush and start in the same IDLE cycle: flush wins and the start is dropped.
//  hi/lo change only at FIX, at MTHI/MTLO, or at reset.
//  Overflow is never flagged. The full 2*WORD_W product is always exact.
// CONFIGURATION
//  MULDIV_DIVZERO_EN defined, DIV/DIVU with rt_data==0:
//    Skip RUN. Write hi=rs_data, lo=all-ones at E0+1.
//    done and divz pulse together in the following cycle.
//  MULDIV_DIVZERO_EN undefined:
//    No divz port. Divide by zero runs the full latency.
//    Unsigned result: hi=rs, lo=all-ones.
//    Signed result: hi=rs, lo=(rs<0 ? 1 : all-ones).
// TESTING
//  T1 MULTU FFFFFFFFh x FFFFFFFFh -> hi=FFFFFFFEh, lo=00000001h; done exactly 33 cycles after E0.
//  T2 MULT -3 x 5 -> hi=FFFFFFFFh, lo=FFFFFFF1h.
//     DIV -7 / 2 -> lo=FFFFFFFDh, hi=FFFFFFFFh.
//     DIVU 100 / 7 -> lo=14, hi=2.
//  T3 DIVU started; start MULT at cycle 5 -> ignored.
//     flush at cycle 10 -> busy=0 next cycle; no done; hi/lo unchanged.
//  T4 MTHI 1234h then MTLO 5678h on back-to-back cycles -> hi=1234h, lo=5678h; done never asserted.
//  T5 DIVU 5 / 0, macro on -> done=divz=1 at E0+1, hi=5, lo=FFFFFFFFh.
//     Macro off -> same hi/lo after 33 cycles.
//  T6 RST pulsed mid-RUN -> busy/done/hi/lo=0 immediately, without waiting for a clock.
//     The next MULTU 6 x 7 gives lo=42.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or restoring-subtract step per cycle.
// Optional macro MULDIV_DIVZERO_EN: short-cuts divide-by-zero and adds the divz pulse output.
module muldiv_sequencer #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [5:0]        func,
  input  logic [WORD_W-1:0] rs_data,
  input  logic [WORD_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
`ifdef MULDIV_DIVZERO_EN
  ,
  output logic              divz
`endif
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int         CNT_W   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              rs_neg_q, rs_neg_d;
  logic              rt_neg_q, rt_neg_d;
  logic [WORD_W-1:0] acc_hi_q, acc_hi_d;
  logic [WORD_W-1:0] acc_lo_q, acc_lo_d;
  logic [WORD_W-1:0] opb_q, opb_d;
  logic [WORD_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
  logic              dz_q, dz_d;
  logic              divz_q, divz_d;
`endif

  // Operand decode in IDLE
  logic              is_mul, is_div, is_sgn, rs_neg_in, rt_neg_in;
  logic [WORD_W-1:0] abs_rs, abs_rt;

  assign is_mul    = (func == F_MULT) || (func == F_MULTU);
  assign is_div    = (func == F_DIV)  || (func == F_DIVU);
  assign is_sgn    = (func == F_MULT) || (func == F_DIV);
  assign rs_neg_in = is_sgn & rs_data[WORD_W-1];
  assign rt_neg_in = is_sgn & rt_data[WORD_W-1];
  assign abs_rs    = rs_neg_in ? -rs_data : rs_data;
  assign abs_rt    = rt_neg_in ? -rt_data : rt_data;

  // One iteration of each algorithm; the partial remainder is WORD_W+1 bits after the shift
  logic [WORD_W-1:0]   mul_add;
  logic [WORD_W:0]     mul_sum;
  logic [WORD_W:0]     div_shift;
  logic                div_ge;
  logic [WORD_W-1:0]   div_sub;
  logic                res_neg;
  logic [2*WORD_W-1:0] prod, prod_fix;
  logic [WORD_W-1:0]   quo_fix, rem_fix;

  assign mul_add   = acc_lo_q[0] ? opb_q : '0;
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, mul_add};
  assign div_shift = {acc_hi_q, acc_lo_q[WORD_W-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_sub   = div_shift[WORD_W-1:0] - opb_q;
  assign res_neg   = rs_neg_q ^ rt_neg_q;
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_fix  = res_neg ? -prod : prod;
  assign quo_fix   = res_neg ? -acc_lo_q : acc_lo_q;
  assign rem_fix   = rs_neg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    rs_neg_d = rs_neg_q;
    rt_neg_d = rt_neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dz_d     = dz_q;
    divz_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_mul || is_div) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            div_d    = is_div;
            rs_neg_d = rs_neg_in;
            rt_neg_d = rt_neg_in;
            acc_hi_d = '0;
            acc_lo_d = is_div ? abs_rs : abs_rt;
            opb_d    = is_div ? abs_rt : abs_rs;
`ifdef MULDIV_DIVZERO_EN
            dz_d     = is_div && (rt_data == '0);
            if (is_div && (rt_data == '0)) begin
              state_d  = S_FIX;
              acc_hi_d = rs_data;
              acc_lo_d = '1;
            end
`endif
          end else if (func == F_MTHI) begin
            hi_d = rs_data;
          end else if (func == F_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
          if (div_q) begin
            acc_hi_d = div_ge ? div_sub : div_shift[WORD_W-1:0];
            acc_lo_d = {acc_lo_q[WORD_W-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[WORD_W:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WORD_W-1:1]};
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
`ifdef MULDIV_DIVZERO_EN
          divz_d = dz_q;
          if (dz_q) begin
            hi_d = acc_hi_q;
            lo_d = acc_lo_q;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= 1'b0;
      divz_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= dz_d;
      divz_q   <= divz_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign divz = divz_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO and latency values.
// Follows MULDIV_DIVZERO_EN when defined (divide-by-zero short-cut and divz checks).
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        CLK, RST, start, flush, busy, done;
  logic [5:0]  func;
  logic [31:0] rs_data, rt_data, hi, lo;
`ifdef MULDIV_DIVZERO_EN
  logic        divz;
`endif

  int errors = 0;
  int checks = 0;
  int lat, bcnt, dcnt;

  muldiv_sequencer #(.WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .func(func),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_EN
    , .divz(divz)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op; lat = samples after E0 until done (-1 on timeout), bc = busy samples before done
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lt, output int bc);
    @(negedge CLK);
    start = 1'b1; func = f; rs_data = a; rt_data = b;
    @(posedge CLK); #1;
    start = 1'b0;
    lt = -1; bc = 0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        lt = n;
        break;
      end
      if (busy) bc++;
      @(posedge CLK); #1;
    end
  endtask

  // Watch n cycles, counting done and busy samples
  task automatic watch(input int n, output int dc, output int bc);
    dc = 0; bc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (done) dc++;
      if (busy) bc++;
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; flush = 1'b0; func = '0; rs_data = '0; rt_data = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    #11 RST = 1'b0;

    // T1: unsigned max x max, exact latency
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("t1_latency", lat, 33);
    chk("t1_busy_cycles", bcnt, 33);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);
    @(posedge CLK); #1;
    chk("t1_done_pulse", done, 0);

    // T2: signed/unsigned arithmetic
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
    chk("mult_lat", lat, 33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    chk("div_negdiv_hi", hi, 32'd1);
    run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    chk("mult_minint_hi", hi, 32'h4000_0000);
    chk("mult_minint_lo", lo, 32'h0000_0000);
    run_op(F_DIVU, 32'd100, 32'd7, lat, bcnt);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // Unknown func is ignored
    @(negedge CLK);
    start = 1'b1; func = 6'h20; rs_data = 32'hDEAD_BEEF; rt_data = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("badfunc_busy", busy, 0);
    chk("badfunc_hilo", {hi, lo}, {32'd2, 32'd14});

    // flush and start together in IDLE: start dropped
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; func = F_MULTU; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);
    watch(40, dcnt, bcnt);
    chk("flush_start_no_done", dcnt, 0);
    chk("flush_start_hilo", {hi, lo}, {32'd2, 32'd14});

    // T3: start while busy ignored; flush mid-RUN aborts
    @(negedge CLK);
    start = 1'b1; func = F_DIVU; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    start = 1'b1; func = F_MULT; rs_data = 32'd11; rt_data = 32'd13;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("t3_still_busy", busy, 1);
    repeat (3) @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("t3_flush_busy", busy, 0);
    chk("t3_flush_done", done, 0);
    watch(40, dcnt, bcnt);
    chk("t3_no_done", dcnt, 0);
    chk("t3_no_busy", bcnt, 0);
    chk("t3_hilo", {hi, lo}, {32'd2, 32'd14});

    // Flush during FIX suppresses the write and done
    @(negedge CLK);
    start = 1'b1; func = F_DIVU; rs_data = 32'd9; rt_data = 32'd2;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (32) @(posedge CLK);
    #1;
    chk("fix_busy", busy, 1);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("fix_flush_busy", busy, 0);
    chk("fix_flush_done", done, 0);
    chk("fix_flush_hilo", {hi, lo}, {32'd2, 32'd14});

    // T4: MTHI then MTLO back-to-back
    @(negedge CLK);
    start = 1'b1; func = F_MTHI; rs_data = 32'h1234;
    @(posedge CLK); #1;
    chk("t4_mthi_hi", hi, 32'h1234);
    chk("t4_mthi_lo", lo, 32'd14);
    chk("t4_mthi_busy", busy, 0);
    chk("t4_mthi_done", done, 0);
    func = F_MTLO; rs_data = 32'h5678;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("t4_hilo", {hi, lo}, {32'h1234, 32'h5678});
    watch(3, dcnt, bcnt);
    chk("t4_no_done", dcnt, 0);

    // T5: divide by zero
    run_op(F_DIVU, 32'd5, 32'd0, lat, bcnt);
`ifdef MULDIV_DIVZERO_EN
    chk("t5_lat", lat, 1);
    chk("t5_divz", divz, 1);
`else
    chk("t5_lat", lat, 33);
`endif
    chk("t5_hi", hi, 32'd5);
    chk("t5_lo", lo, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'hFFFF_FFFC, 32'd0, lat, bcnt);
    chk("t5s_hi", hi, 32'hFFFF_FFFC);
`ifdef MULDIV_DIVZERO_EN
    chk("t5s_lo", lo, 32'hFFFF_FFFF);
`else
    chk("t5s_lo", lo, 32'd1);
`endif

    // T6: async reset mid-RUN, then a clean op
    @(negedge CLK);
    start = 1'b1; func = F_MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_hilo", {hi, lo}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_op(F_MULTU, 32'd6, 32'd7, lat, bcnt);
    chk("t6_lat", lat, 33);
    chk("t6_lo", lo, 32'd42);
    chk("t6_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
